// File: rtl/cdc_toggle_rx_multi.sv
// Multi-channel toggle-CDC receiver: per-channel sync chain, 1-deep valid/ready holding register, ack toggle, sticky overrun.
// Optional per-channel saturating drop counters (output overrun_cnt) when CDC_RX_OVERRUN_CNT_EN is defined.
`timescale 1ns/1ps
module cdc_toggle_rx_multi #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          tog_in,
    input  logic [CHANNELS*WIDTH-1:0]    data_in,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic [CHANNELS-1:0]          ack_tog,
    output logic [CHANNELS-1:0]          overrun,
    input  logic [CHANNELS-1:0]          overrun_clr
`ifdef CDC_RX_OVERRUN_CNT_EN
    ,
    output logic [CHANNELS*8-1:0]        overrun_cnt
`endif
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   tog_d_reg;
            logic                   valid_reg;
            logic                   ack_reg;
            logic                   overrun_reg;
            logic [WIDTH-1:0]       data_reg;
            logic                   tog_edge;
            logic                   accept;
            logic                   drop;

            assign tog_edge = sync_reg[SYNC_STAGES-1] ^ tog_d_reg;
            assign accept   = valid_reg & out_ready[gi];
            // An edge that finds the register full and not draining is lost, never re-detected.
            assign drop     = tog_edge & valid_reg & ~out_ready[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg    <= '0;
                    tog_d_reg   <= 1'b0;
                    valid_reg   <= 1'b0;
                    ack_reg     <= 1'b0;
                    overrun_reg <= 1'b0;
                    data_reg    <= '0;
                end else begin
                    sync_reg  <= {sync_reg[SYNC_STAGES-2:0], tog_in[gi]};
                    tog_d_reg <= sync_reg[SYNC_STAGES-1];
                    if (accept) begin
                        ack_reg <= ~ack_reg;
                    end
                    if (tog_edge && (!valid_reg || accept)) begin
                        data_reg  <= data_in[gi*WIDTH +: WIDTH];
                        valid_reg <= 1'b1;
                    end else if (accept) begin
                        valid_reg <= 1'b0;
                    end
                    if (drop) begin
                        overrun_reg <= 1'b1;
                    end else if (overrun_clr[gi]) begin
                        overrun_reg <= 1'b0;
                    end
                end
            end

            assign out_valid[gi]                 = valid_reg;
            assign out_data[gi*WIDTH +: WIDTH]   = data_reg;
            assign ack_tog[gi]                   = ack_reg;
            assign overrun[gi]                   = overrun_reg;

`ifdef CDC_RX_OVERRUN_CNT_EN
            logic [7:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 8'd0;
                end else if (drop) begin
                    if (cnt_reg != 8'hFF) begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end else if (overrun_clr[gi]) begin
                    cnt_reg <= 8'd0;
                end
            end

            assign overrun_cnt[gi*8 +: 8] = cnt_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_cdc_toggle_rx_multi.sv
// Scoreboard bench for cdc_toggle_rx_multi: directed channel tests on one instance,
// ack-gated multi-rate sender traffic on a second instance with SYNC_STAGES=3.
`timescale 1ns/1ps
module tb_cdc_toggle_rx_multi;

    int tests = 0;
    int fails = 0;

    // ---------------- directed instance ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tog_in = 2'b00;
    logic [3:0] data0 = 4'h0;
    logic [3:0] data1 = 4'h0;
    logic [1:0] out_valid;
    logic [1:0] out_ready = 2'b00;
    logic [7:0] out_data;
    logic [1:0] ack_tog;
    logic [1:0] overrun;
    logic [1:0] overrun_clr = 2'b00;
    logic [15:0] overrun_cnt;

    always #5 clk = ~clk;

    cdc_toggle_rx_multi #(.CHANNELS(2), .WIDTH(4), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .tog_in(tog_in), .data_in({data1, data0}),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ack_tog(ack_tog), .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef CDC_RX_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );
`ifndef CDC_RX_OVERRUN_CNT_EN
    assign overrun_cnt = '0;
`endif

    // ---------------- traffic instance ----------------
    logic       clk3 = 1'b0;
    logic       sclk = 1'b0;
    logic       rst3 = 1'b1;
    int         rx_half = 9;
    logic       tog3_0 = 1'b0, tog3_1 = 1'b0;
    logic [3:0] data3_0 = 4'h0, data3_1 = 4'h0;
    logic [1:0] valid3;
    logic [1:0] ready3 = 2'b00;
    logic [7:0] odata3;
    logic [1:0] ack3;
    logic [1:0] ovr3;
    logic [15:0] cnt3;
    logic [1:0] ack3_s1 = 2'b00, ack3_s2 = 2'b00;

    initial forever #(rx_half) clk3 = ~clk3;
    always #10 sclk = ~sclk;

    cdc_toggle_rx_multi #(.CHANNELS(2), .WIDTH(4), .SYNC_STAGES(3)) u_dut3 (
        .clk(clk3), .rst(rst3), .tog_in({tog3_1, tog3_0}), .data_in({data3_1, data3_0}),
        .out_valid(valid3), .out_ready(ready3), .out_data(odata3),
        .ack_tog(ack3), .overrun(ovr3), .overrun_clr(2'b00)
`ifdef CDC_RX_OVERRUN_CNT_EN
        , .overrun_cnt(cnt3)
`endif
    );
`ifndef CDC_RX_OVERRUN_CNT_EN
    assign cnt3 = '0;
`endif

    always @(posedge sclk) begin
        ack3_s1 <= ack3;
        ack3_s2 <= ack3_s1;
    end

    initial forever begin
        @(posedge clk3);
        #1;
        ready3[0] = ($urandom_range(0, 3) != 0);
        ready3[1] = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard ----------------
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] q3_0[$];
    logic [3:0] q3_1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int which, input logic [3:0] act);
        logic [3:0] e;
        bit         got;
        got = 1'b0;
        e   = 4'h0;
        if (which == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        if (which == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        if (which == 2 && q3_0.size() > 0) begin e = q3_0.pop_front(); got = 1'b1; end
        if (which == 3 && q3_1.size() > 0) begin e = q3_1.pop_front(); got = 1'b1; end
        tests++;
        if (!got) begin
            fails++;
            $display("[TB] FAIL sb_unexpected q%0d: got %h, expected no word", which, act);
        end else if (act !== e) begin
            fails++;
            $display("[TB] FAIL sb_data q%0d: got %h, expected %h", which, act, e);
        end else begin
            $display("[TB] q%0d accept data=%h", which, act);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid[0] && out_ready[0]) pop_check(0, out_data[3:0]);
            if (out_valid[1] && out_ready[1]) pop_check(1, out_data[7:4]);
        end
    end

    always @(negedge clk3) begin
        if (!rst3) begin
            if (valid3[0] && ready3[0]) pop_check(2, odata3[3:0]);
            if (valid3[1] && ready3[1]) pop_check(3, odata3[7:4]);
        end
    end

    // Counts posedges starting with the one that first samples the new tog_in level.
    task automatic wait_valid(input int ch, input int exp_cyc, input string name);
        int c;
        c = 0;
        do begin
            @(posedge clk);
            c++;
            @(negedge clk);
        end while (!out_valid[ch] && c < 20);
        check(name, c, exp_cyc);
    endtask

    task automatic pulse_clr0();
        @(posedge clk); #1 overrun_clr[0] = 1'b1;
        @(posedge clk); #1 overrun_clr[0] = 1'b0;
    endtask

    task automatic send_ch(input int ch);
        int         t;
        int         gap;
        logic [3:0] d;
        for (int m = 0; m < 3; m++) begin
            for (int w = 0; w <= 20; w++) begin
                t = 0;
                while (((ch == 0) ? (ack3_s2[0] != tog3_0) : (ack3_s2[1] != tog3_1)) && t < 400) begin
                    @(posedge sclk);
                    t++;
                end
                if (t >= 400) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL t6_ack_timeout ch%0d: got no ack, expected ack within 400 cycles", ch);
                end
                if (w < 20) begin
                    gap = (m == 0) ? 0 : (m == 1) ? 8 : int'($urandom_range(0, 5));
                    repeat (gap) @(posedge sclk);
                    @(posedge sclk);
                    #1;
                    d = 4'($urandom);
                    if (ch == 0) begin
                        q3_0.push_back(d); data3_0 = d; tog3_0 = ~tog3_0;
                    end else begin
                        q3_1.push_back(d); data3_1 = d; tog3_1 = ~tog3_1;
                    end
                end
            end
        end
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ack", ack_tog, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cnt", overrun_cnt, 0);

        // ---- 1: single transfer, ready high ----
        @(posedge clk); #1;
        out_ready = 2'b11;
        data0 = 4'hA; q0.push_back(4'hA); tog_in[0] = 1'b1;
        wait_valid(0, 3, "t1_latency");
        check("t1_data", out_data[3:0], 4'hA);
        @(negedge clk);
        check("t1_pulse", out_valid[0], 0);
        check("t1_ack0", ack_tog[0], 1);
        check("t1_ch1_valid", out_valid[1], 0);
        check("t1_ch1_ack", ack_tog[1], 0);

        // ---- 2: overrun while full ----
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        data0 = 4'h3; q0.push_back(4'h3); tog_in[0] = 1'b0;
        wait_valid(0, 3, "t2_latency");
        @(posedge clk); #1;
        data0 = 4'h5; tog_in[0] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t2_data_held", out_data[3:0], 4'h3);
        check("t2_valid_held", out_valid[0], 1);
        check("t2_overrun", overrun[0], 1);
        check("t2_ack_unchanged", ack_tog[0], 1);
`ifdef CDC_RX_OVERRUN_CNT_EN
        check("t2_cnt", overrun_cnt[7:0], 1);
`endif
        @(posedge clk); #1 out_ready[0] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_no_redetect", out_valid[0], 0);
        check("t2_ack_after", ack_tog[0], 0);

        // ---- 3: back-to-back, second edge on the accept cycle ----
        @(posedge clk); #1;
        data0 = 4'h7; q0.push_back(4'h7); tog_in[0] = 1'b0;
        @(posedge clk); #1;
        tog_in[0] = 1'b1; q0.push_back(4'h9);
        @(posedge clk);
        @(posedge clk); #1;
        data0 = 4'h9;
        @(negedge clk);
        check("t3_w1_valid", out_valid[0], 1);
        check("t3_w1_data", out_data[3:0], 4'h7);
        @(negedge clk);
        check("t3_w2_valid", out_valid[0], 1);
        check("t3_w2_data", out_data[3:0], 4'h9);
        check("t3_ack_mid", ack_tog[0], 1);
        @(negedge clk);
        check("t3_idle", out_valid[0], 0);
        check("t3_ack_end", ack_tog[0], 0);

        // ---- 4: set wins over clear, then saturation ----
        check("t4_sticky", overrun[0], 1);
        pulse_clr0();
        @(negedge clk);
        check("t4_cleared", overrun[0], 0);
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        data0 = 4'hB; q0.push_back(4'hB); tog_in[0] = 1'b0;
        wait_valid(0, 3, "t4_latency");
        @(posedge clk); #1;
        data0 = 4'hC; tog_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 overrun_clr[0] = 1'b1;
        @(posedge clk); #1 overrun_clr[0] = 1'b0;
        @(negedge clk);
        check("t4_set_wins", overrun[0], 1);
`ifdef CDC_RX_OVERRUN_CNT_EN
        check("t4_cnt_inc_wins", overrun_cnt[7:0], 1);
`endif
        pulse_clr0();
        @(negedge clk);
        check("t4_clr_alone", overrun[0], 0);
`ifdef CDC_RX_OVERRUN_CNT_EN
        check("t4_cnt_clr", overrun_cnt[7:0], 0);
`endif
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1 tog_in[0] = ~tog_in[0];
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t4_sat_overrun", overrun[0], 1);
        check("t4_sat_data", out_data[3:0], 4'hB);
        check("t4_sat_ack", ack_tog[0], 0);
`ifdef CDC_RX_OVERRUN_CNT_EN
        check("t4_sat_cnt", overrun_cnt[7:0], 255);
`endif
        @(posedge clk); #1 out_ready[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_drain_valid", out_valid[0], 0);
        check("t4_drain_ack", ack_tog[0], 1);

        // ---- 5: reset with pending word and tog_in[1] high ----
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        data1 = 4'h6; tog_in[1] = 1'b1;
        wait_valid(1, 3, "t5_pending");
        check("t5_pending_data", out_data[7:4], 4'h6);
        @(posedge clk); #1;
        rst = 1'b1; tog_in[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_ack", ack_tog, 0);
        check("t5_rst_overrun", overrun, 0);
        check("t5_rst_cnt", overrun_cnt, 0);
        out_ready[1] = 1'b1;
        data1 = 4'hD; q1.push_back(4'hD);
        @(posedge clk); #1 rst = 1'b0;
        wait_valid(1, 3, "t5_spurious_latency");
        check("t5_spurious_data", out_data[7:4], 4'hD);
        check("t5_ch0_quiet", out_valid[0], 0);
        @(negedge clk);
        check("t5_pulse", out_valid[1], 0);
        check("t5_ack1", ack_tog[1], 1);
        check("t5_q0_empty", q0.size(), 0);
        check("t5_q1_empty", q1.size(), 0);

        // ---- 6: ack-gated traffic, 18 ns then 22 ns receiver clock ----
        repeat (3) @(posedge clk3);
        #1 rst3 = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rx_half = (p == 0) ? 9 : 11;
            fork
                send_ch(0);
                send_ch(1);
            join
            repeat (10) @(posedge clk3);
            @(negedge clk3);
            check("t6_q0_empty", q3_0.size(), 0);
            check("t6_q1_empty", q3_1.size(), 0);
            check("t6_overrun", ovr3, 0);
            check("t6_cnt", cnt3, 0);
            check("t6_idle", valid3, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
